// File: rtl/utopia_phy_cell_src.sv
// Utopia Level 1 PHY-side cell source: buffers DEPTH cells written as a byte stream and replays
// them under the cell-level en/clav handshake. Define HEC_GEN_EN to regenerate byte 4 as the HEC.
module utopia_phy_cell_src #(
  parameter int CELL_BYTES = 53,
  parameter int DEPTH      = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic        in_sop,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        frame_err,
  output logic        soc,
  output logic [7:0]  data,
  output logic        clav,
  input  logic        en,
  output logic [15:0] cells_sent
);
  localparam int IDX_W  = $clog2(CELL_BYTES);
  localparam int SLOT_W = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int MEM_N  = DEPTH * CELL_BYTES;
  localparam int ADDR_W = $clog2(MEM_N);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CELL_BYTES - 1);

  typedef enum logic {IDLE, XFER} state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  wr_idx_q, rd_idx_q, wr_pos;
  logic [SLOT_W-1:0] wr_slot_q, rd_slot_q;
  logic [CNT_W-1:0]  avail_q;
  logic [ADDR_W-1:0] wr_addr, rd_addr;
  logic [7:0]        wr_byte;
  logic [7:0]        mem [MEM_N];
  logic              wr_fire, wr_restart, wr_drop, wr_store, wr_commit;
  logic              rd_start, rd_step, rd_release;

  // Occupancy is committed cells plus the one on the wire; the slot being filled is never counted.
  assign in_ready = (int'(avail_q) + int'(state_q == XFER)) < DEPTH;

  assign wr_fire    = in_valid & in_ready;
  assign wr_restart = wr_fire & in_sop & (wr_idx_q != '0);
  assign wr_drop    = wr_fire & ~in_sop & (wr_idx_q == '0);
  assign wr_store   = wr_fire & ~wr_drop;
  assign wr_pos     = in_sop ? '0 : wr_idx_q;
  assign wr_commit  = wr_store & (wr_pos == LAST_IDX);
  assign wr_addr    = ADDR_W'(int'(wr_slot_q) * CELL_BYTES + int'(wr_pos));
  assign rd_addr    = ADDR_W'(int'(rd_slot_q) * CELL_BYTES + int'(rd_idx_q));

`ifdef HEC_GEN_EN
  logic [7:0] crc_q, crc_base;

  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic [7:0] b);
    logic [7:0] c;
    c = crc ^ b;
    for (int i = 0; i < 8; i++) c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    return c;
  endfunction

  assign crc_base = (wr_pos == '0) ? 8'h00 : crc_q;
  assign wr_byte  = (wr_pos == IDX_W'(4)) ? (crc_q ^ 8'h55) : in_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_q <= 8'h00;
    end else if (wr_store && (wr_pos < IDX_W'(4))) begin
      crc_q <= crc8_step(crc_base, in_data);
    end
  end
`else
  assign wr_byte = in_data;
`endif

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_idx_q  <= '0;
      wr_slot_q <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= wr_restart | wr_drop;
      if (wr_store) begin
        if (wr_commit) begin
          wr_idx_q  <= '0;
          wr_slot_q <= wr_slot_q + SLOT_W'(1);
        end else begin
          wr_idx_q <= wr_pos + IDX_W'(1);
        end
      end
    end
  end

  // NOTE: the cell buffer is not reset; stale bytes are unreachable until a slot is recommitted.
  always_ff @(posedge clk) begin
    if (wr_store) mem[wr_addr] <= wr_byte;
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    rd_start = 1'b0;
    rd_step  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!en && (avail_q != '0)) begin
          rd_start = 1'b1;
          state_d  = XFER;
        end
      end
      XFER: begin
        if (!en) begin
          rd_step = 1'b1;
          if (rd_idx_q == LAST_IDX) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign rd_release = rd_step & (rd_idx_q == LAST_IDX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rd_idx_q   <= '0;
      rd_slot_q  <= '0;
      avail_q    <= '0;
      soc        <= 1'b0;
      data       <= 8'h00;
      clav       <= 1'b0;
      cells_sent <= 16'd0;
    end else begin
      state_q <= state_d;
      clav    <= (avail_q != '0);
      soc     <= rd_start;
      if (rd_start || rd_step) data <= mem[rd_addr];

      if (rd_start) begin
        rd_idx_q <= IDX_W'(1);
      end else if (rd_release) begin
        rd_idx_q   <= '0;
        rd_slot_q  <= rd_slot_q + SLOT_W'(1);
        cells_sent <= cells_sent + 16'd1;
      end else if (rd_step) begin
        rd_idx_q <= rd_idx_q + IDX_W'(1);
      end

      // A commit and a start on the same edge cancel out.
      case ({wr_commit, rd_start})
        2'b10:   avail_q <= avail_q + CNT_W'(1);
        2'b01:   avail_q <= avail_q - CNT_W'(1);
        default: avail_q <= avail_q;
      endcase
    end
  end

endmodule

// File: tb/tb_utopia_phy_cell_src.sv
// Self-checking bench for utopia_phy_cell_src: directed sequences, a HEC vector table and random
// traffic, all compared every cycle against a cell-queue reference model.
module tb_utopia_phy_cell_src;
  localparam int CELL_BYTES = 53;
  localparam int DEPTH      = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_sop, in_ready, frame_err, soc, clav, en;
  logic [7:0]  in_data, data;
  logic [15:0] cells_sent;

  int errors = 0;
  int checks = 0;
  int ferr_seen = 0;
  int last_wait = 0;

  // Reference model: committed cells as one byte stream, the cell on the wire, the partial cell.
  logic [7:0] m_fifo[$];
  logic [7:0] m_xfer[$];
  logic [7:0] m_part[$];
  logic [7:0] wq[$];
  logic [7:0] m_data;
  logic       m_soc, m_clav, m_ferr;
  int         m_sent;

  typedef struct {
    logic [31:0] hdr;
    logic [7:0]  b4;
    logic [7:0]  hec_exp;
    int          lead;
  } hec_vec_t;

  hec_vec_t vt [4];

  utopia_phy_cell_src #(.CELL_BYTES(CELL_BYTES), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sop(in_sop), .in_data(in_data),
    .in_ready(in_ready), .frame_err(frame_err), .soc(soc), .data(data), .clav(clav),
    .en(en), .cells_sent(cells_sent)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_timeout(input string name, input int waited);
    checks++;
    errors++;
    $display("FAIL %s: waited %0d cycles, budget exceeded", name, waited);
  endtask

`ifdef HEC_GEN_EN
  function automatic logic [7:0] ref_hec(input logic [31:0] hdr);
    logic [7:0] c;
    logic       fb;
    c = 8'h00;
    for (int i = 31; i >= 0; i--) begin
      fb = c[7] ^ hdr[i];
      c  = {c[6:0], 1'b0};
      if (fb) c = c ^ 8'h07;
    end
    return c;
  endfunction
`endif

  function automatic logic [7:0] byte4_of(input logic [7:0] d);
`ifdef HEC_GEN_EN
    return ref_hec({m_part[0], m_part[1], m_part[2], m_part[3]}) ^ 8'h55;
`else
    return d;
`endif
  endfunction

  function automatic logic model_ready();
    return ((m_fifo.size() / CELL_BYTES) + ((m_xfer.size() != 0) ? 1 : 0)) < DEPTH;
  endfunction

  task automatic model_reset();
    m_fifo.delete();
    m_xfer.delete();
    m_part.delete();
    m_data = 8'h00;
    m_soc  = 1'b0;
    m_clav = 1'b0;
    m_ferr = 1'b0;
    m_sent = 0;
  endtask

  task automatic model_edge(input logic v, input logic s, input logic [7:0] d, input logic e);
    logic rdy;
    rdy    = model_ready();
    m_clav = (m_fifo.size() >= CELL_BYTES);
    m_soc  = 1'b0;
    m_ferr = 1'b0;
    if (m_xfer.size() != 0) begin
      if (!e) begin
        m_data = m_xfer.pop_front();
        if (m_xfer.size() == 0) m_sent++;
      end
    end else if (!e && (m_fifo.size() >= CELL_BYTES)) begin
      for (int k = 0; k < CELL_BYTES; k++) m_xfer.push_back(m_fifo.pop_front());
      m_data = m_xfer.pop_front();
      m_soc  = 1'b1;
    end
    if (v && rdy) begin
      if (s) begin
        m_ferr = (m_part.size() != 0);
        m_part.delete();
        m_part.push_back(d);
      end else if (m_part.size() == 0) begin
        m_ferr = 1'b1;
      end else if (m_part.size() == 4) begin
        m_part.push_back(byte4_of(d));
      end else begin
        m_part.push_back(d);
      end
      if (m_part.size() == CELL_BYTES) begin
        foreach (m_part[k]) m_fifo.push_back(m_part[k]);
        m_part.delete();
      end
    end
  endtask

  // One clock: drive at the falling edge, update the model at the rising edge, sample 1 ns later.
  task automatic step(input logic v, input logic s, input logic [7:0] d, input logic e);
    in_valid = v;
    in_sop   = s;
    in_data  = d;
    en       = e;
    @(posedge clk);
    model_edge(v, s, d, e);
    #1;
    check("soc", soc, m_soc);
    check("data", data, m_data);
    check("clav", clav, m_clav);
    check("in_ready", in_ready, model_ready());
    check("frame_err", frame_err, m_ferr);
    check("cells_sent", cells_sent, 16'(m_sent));
    if (frame_err) ferr_seen++;
    @(negedge clk);
  endtask

  task automatic write_q(input logic en_v);
    int i = 0;
    int waited = 0;
    while (i < wq.size()) begin
      if (model_ready()) begin
        step(1'b1, i == 0, wq[i], en_v);
        i++;
      end else begin
        step(1'b0, 1'b0, 8'h00, en_v);
        waited++;
        if (waited > 400) begin
          fail_timeout("write_wait", waited);
          return;
        end
      end
    end
    last_wait = waited;
  endtask

  task automatic drain();
    int n = 0;
    while (m_fifo.size() != 0 || m_xfer.size() != 0) begin
      step(1'b0, 1'b0, 8'h00, 1'b0);
      n++;
      if (n > 400) begin
        fail_timeout("drain", n);
        return;
      end
    end
  endtask

  task automatic fill_q(input logic [7:0] base, input int n);
    wq.delete();
    for (int i = 0; i < n; i++) wq.push_back(base + 8'(i));
  endtask

  initial begin
    int f0;
    int gen_idx;
    logic [7:0] exp_b4;

    vt[0] = '{hdr: 32'h0000_0001, b4: 8'hFF, hec_exp: 8'h52, lead: 2};
    vt[1] = '{hdr: 32'h0000_0000, b4: 8'hA5, hec_exp: 8'h55, lead: 3};
    vt[2] = '{hdr: 32'h0100_0000, b4: 8'h00, hec_exp: 8'h43, lead: 2};
    vt[3] = '{hdr: 32'h0000_0001, b4: 8'h52, hec_exp: 8'h52, lead: 5};

    rst_n = 1'b0; in_valid = 1'b0; in_sop = 1'b0; in_data = 8'h00; en = 1'b1;
    model_reset();
    #3;
    check("rst_soc", soc, 1'b0);
    check("rst_data", data, 8'h00);
    check("rst_clav", clav, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_frame_err", frame_err, 1'b0);
    check("rst_cells_sent", cells_sent, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single cell 0x00..0x34, replayed back to back with en held low.
    fill_q(8'h00, CELL_BYTES);
    write_q(1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    check("t1_clav", clav, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b0);
    check("t1_soc", soc, 1'b1);
    check("t1_byte0", data, 8'h00);
    for (int k = 1; k < CELL_BYTES; k++) step(1'b0, 1'b0, 8'h00, 1'b0);
    check("t1_byte52", data, 8'h34);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    check("t1_clav_low", clav, 1'b0);
    check("t1_sent", cells_sent, 16'd1);

    // Buffer full: a third cell must wait until the first cell's last byte is driven.
    for (int c = 0; c < DEPTH; c++) begin
      fill_q(8'(c * 64), CELL_BYTES);
      write_q(1'b1);
    end
    check("full_ready_low", in_ready, 1'b0);
    fill_q(8'hA0, CELL_BYTES);
    write_q(1'b0);
    check("full_wait", last_wait, 53);
    drain();
    check("full_sent", cells_sent, 16'd4);

    // Pause for three cycles with byte 9 on the bus.
    fill_q(8'h80, CELL_BYTES);
    write_q(1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    for (int k = 0; k < 10; k++) step(1'b0, 1'b0, 8'h00, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b0, 8'h00, 1'b1);
      check("pause_hold", data, 8'h89);
      check("pause_soc", soc, 1'b0);
    end
    step(1'b0, 1'b0, 8'h00, 1'b0);
    check("pause_resume", data, 8'h8A);
    drain();
    check("pause_sent", cells_sent, 16'd5);

    // Restart at wr_idx 20, then a stray byte with no start of cell.
    f0 = ferr_seen;
    fill_q(8'hC0, 20);
    write_q(1'b1);
    fill_q(8'h40, CELL_BYTES);
    write_q(1'b1);
    check("ferr_once", ferr_seen - f0, 1);
    drain();
    check("ferr_sent", cells_sent, 16'd6);
    step(1'b1, 1'b0, 8'h77, 1'b1);
    check("ferr_drop", frame_err, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    check("ferr_clear", frame_err, 1'b0);

    // Byte 4 handling across header vectors.
    for (int r = 0; r < 4; r++) begin
      wq.delete();
      for (int b = 3; b >= 0; b--) wq.push_back(vt[r].hdr[b*8 +: 8]);
      wq.push_back(vt[r].b4);
      for (int i = 5; i < CELL_BYTES; i++) wq.push_back(8'(r * 16 + i));
`ifdef HEC_GEN_EN
      exp_b4 = vt[r].hec_exp;
`else
      exp_b4 = vt[r].b4;
`endif
      write_q(1'b1);
      for (int k = 0; k < vt[r].lead; k++) step(1'b0, 1'b0, 8'h00, 1'b1);
      step(1'b0, 1'b0, 8'h00, 1'b0);
      check("hec_soc", soc, 1'b1);
      check("hec_byte0", data, vt[r].hdr[31:24]);
      for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 8'h00, 1'b0);
      check("hec_byte4", data, exp_b4);
      drain();
    end
    check("hec_sent", cells_sent, 16'd10);

    // Random traffic with occasional framing errors and random flow control.
    gen_idx = 0;
    for (int t = 0; t < 1200; t++) begin
      logic v, s, e, rdy;
      v   = ($urandom_range(0, 99) < 75);
      s   = (gen_idx == 0) ? ($urandom_range(0, 49) != 0) : ($urandom_range(0, 199) == 0);
      e   = ($urandom_range(0, 99) < 30);
      rdy = model_ready();
      step(v, s, 8'($urandom), e);
      if (v && rdy) begin
        if (s) gen_idx = 1;
        else if (gen_idx != 0) gen_idx = gen_idx + 1;
        if (gen_idx == CELL_BYTES) gen_idx = 0;
      end
    end
    drain();

    // Reset while the wire is at rd_idx 30 and another cell is committed.
    fill_q(8'h60, CELL_BYTES);
    write_q(1'b1);
    fill_q(8'hE0, CELL_BYTES);
    write_q(1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    for (int k = 0; k < 30; k++) step(1'b0, 1'b0, 8'h00, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_soc", soc, 1'b0);
    check("mid_rst_data", data, 8'h00);
    check("mid_rst_clav", clav, 1'b0);
    check("mid_rst_sent", cells_sent, 16'd0);
    check("mid_rst_ready", in_ready, 1'b1);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    fill_q(8'h20, CELL_BYTES);
    write_q(1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b0);
    check("post_rst_soc", soc, 1'b1);
    check("post_rst_byte0", data, 8'h20);
    drain();
    check("post_rst_sent", cells_sent, 16'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
